// File: rtl/mem_pkg.sv
// Shared types and widths for the per-core memory/mutex initiator.
package mem_pkg;

    localparam int ADR_W  = 16;
    localparam int DAT_W  = 16;
    localparam int LOCK_W = 10;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_LOCK   = 2'b10,
        OP_UNLOCK = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        RDATA = 2'b10,
        DONE  = 2'b11
    } state_t;

    function automatic logic is_mem_op(input op_t op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/core_mem_port_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // count register: clear wins over enable, stop at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/core_mem_port.sv
// Per-core initiator: holds one request toward the memory/mutex arbiter until granted
// and returns a single-cycle completion to the pipeline.
module core_mem_port
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 0,
    parameter int WAIT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADR_W-1:0]  req_adr,
    input  logic [DAT_W-1:0]  req_dat,
    input  logic [LOCK_W-1:0] req_lock_adr,
    output logic              rsp_valid,
    output logic [DAT_W-1:0]  rsp_dat,
    output logic              rsp_err,
    output logic [WAIT_W-1:0] last_wait,
    output logic [ADR_W-1:0]  main_mem_read_adr,
    output logic [ADR_W-1:0]  main_mem_write_adr,
    output logic [DAT_W-1:0]  main_mem_write_dat,
    output logic              main_mem_read,
    output logic              main_mem_write,
    input  logic              main_mem_ac,
    input  logic [DAT_W-1:0]  main_mem_dat,
    output logic [LOCK_W-1:0] lock_adr,
    output logic              lock_en,
    output logic              unlock_en,
    input  logic              lock_ac
);

    localparam bit               LP_TO_EN   = (MAX_WAIT > 0);
    localparam logic [WAIT_W-1:0] LP_TO_LIM  = LP_TO_EN ? WAIT_W'(MAX_WAIT - 1) : '0;
    localparam logic [WAIT_W-1:0] LP_TO_WAIT = WAIT_W'(MAX_WAIT);

    state_t              r_state;
    state_t              w_next;
    op_t                 r_op;
    logic [ADR_W-1:0]    r_adr;
    logic [DAT_W-1:0]    r_dat;
    logic [LOCK_W-1:0]   r_lock_adr;
    logic [DAT_W-1:0]    r_rsp_dat;
    logic                r_rsp_err;
    logic [WAIT_W-1:0]   r_last_wait;
    logic [WAIT_W-1:0]   w_cnt;
    logic                w_accept;
    logic                w_grant;
    logic                w_timeout;

    assign req_ready = ((r_state == IDLE) || (r_state == DONE)) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_grant   = (r_state == REQ) && (is_mem_op(r_op) ? main_mem_ac : lock_ac);
    // timeout fires on the edge where the wait count would reach MAX_WAIT
    assign w_timeout = LP_TO_EN && (r_state == REQ) && !w_grant &&
                       (r_op == OP_LOCK) && (w_cnt == LP_TO_LIM);

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_accept),
        .i_en  ((r_state == REQ) && !w_grant),
        .o_cnt (w_cnt)
    );

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = REQ;
                else          w_next = IDLE;
            end
            REQ: begin
                if (w_grant)        w_next = (r_op == OP_READ) ? RDATA : DONE;
                else if (w_timeout) w_next = DONE;
                else                w_next = REQ;
            end
            RDATA:   w_next = DONE;
            DONE: begin
                if (w_accept) w_next = REQ;
                else          w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // operation latch on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op       <= OP_READ;
            r_adr      <= '0;
            r_dat      <= '0;
            r_lock_adr <= '0;
        end else if (w_accept) begin
            r_op       <= op_t'(req_op);
            r_adr      <= req_adr;
            r_dat      <= req_dat;
            r_lock_adr <= req_lock_adr;
        end
    end

    // response registers, loaded on entry to DONE and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_last_wait <= '0;
        end else if (w_next == DONE) begin
            r_rsp_dat   <= (r_state == RDATA) ? main_mem_dat : '0;
            r_rsp_err   <= w_timeout;
            r_last_wait <= w_timeout ? LP_TO_WAIT : w_cnt;
        end
    end

    assign main_mem_read      = (r_state == REQ) && (r_op == OP_READ);
    assign main_mem_write     = (r_state == REQ) && (r_op == OP_WRITE);
    assign lock_en            = (r_state == REQ) && (r_op == OP_LOCK);
    assign unlock_en          = (r_state == REQ) && (r_op == OP_UNLOCK);
    assign main_mem_read_adr  = r_adr;
    assign main_mem_write_adr = r_adr;
    assign main_mem_write_dat = r_dat;
    assign lock_adr           = r_lock_adr;

    assign rsp_valid = (r_state == DONE);
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign last_wait = r_last_wait;

endmodule

// File: tb/tb_core_mem_port.sv
// Scoreboard bench for core_mem_port: the bench plays arbiter and shared dmem,
// predicts each completion from op/grant delay, and a monitor checks every rsp_valid.
module tb_core_mem_port;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_adr;
    logic [15:0] req_dat;
    logic [9:0]  req_lock_adr;
    logic        rsp_valid;
    logic [15:0] rsp_dat;
    logic        rsp_err;
    logic [15:0] last_wait;
    logic [15:0] main_mem_read_adr;
    logic [15:0] main_mem_write_adr;
    logic [15:0] main_mem_write_dat;
    logic        main_mem_read;
    logic        main_mem_write;
    logic        main_mem_ac;
    logic [15:0] main_mem_dat;
    logic [9:0]  lock_adr;
    logic        lock_en;
    logic        unlock_en;
    logic        lock_ac;

    core_mem_port #(.MAX_WAIT(MAXW), .WAIT_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_op             (req_op),
        .req_adr            (req_adr),
        .req_dat            (req_dat),
        .req_lock_adr       (req_lock_adr),
        .rsp_valid          (rsp_valid),
        .rsp_dat            (rsp_dat),
        .rsp_err            (rsp_err),
        .last_wait          (last_wait),
        .main_mem_read_adr  (main_mem_read_adr),
        .main_mem_write_adr (main_mem_write_adr),
        .main_mem_write_dat (main_mem_write_dat),
        .main_mem_read      (main_mem_read),
        .main_mem_write     (main_mem_write),
        .main_mem_ac        (main_mem_ac),
        .main_mem_dat       (main_mem_dat),
        .lock_adr           (lock_adr),
        .lock_en            (lock_en),
        .unlock_en          (unlock_en),
        .lock_ac            (lock_ac)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dat;
        logic        err;
        logic [15:0] wt;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] ref_mem [0:255];
    logic [15:0] dmem    [0:255];
    int          cur_dly = 0;
    logic [1:0]  cur_op = 2'b00;
    logic [15:0] cur_adr = 16'h0;
    logic [15:0] cur_dat = 16'h0;
    logic [9:0]  cur_ladr = 10'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // shared synchronous dmem: initial contents 0x1234+addr, read data one cycle later
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 16'h1234 + 16'(i);
        end else if (main_mem_write && main_mem_ac) begin
            dmem[main_mem_write_adr[7:0]] <= main_mem_write_dat;
        end
        main_mem_dat <= dmem[main_mem_read_adr[7:0]];
    end

    // arbiter: grants after cur_dly waiting cycles and checks the request lines
    initial begin : arbiter
        int         wcnt;
        logic       granted;
        logic [3:0] lines;
        wcnt        = 0;
        granted     = 1'b0;
        main_mem_ac = 1'b0;
        lock_ac     = 1'b0;
        forever begin
            @(negedge clk);
            lines = {unlock_en, lock_en, main_mem_write, main_mem_read};
            if (granted) check("req_drop_after_grant", 32'(lines), 32'd0);
            granted = 1'b0;
            if (lines != 4'b0000) begin
                check("req_line_select", 32'(lines), 32'(4'b0001 << cur_op));
                if (!cur_op[1]) begin
                    check("mem_read_adr", 32'(main_mem_read_adr), 32'(cur_adr));
                    check("mem_write_adr", 32'(main_mem_write_adr), 32'(cur_adr));
                    if (cur_op == 2'b01) check("mem_write_dat", 32'(main_mem_write_dat), 32'(cur_dat));
                end else begin
                    check("lock_adr", 32'(lock_adr), 32'(cur_ladr));
                end
                granted = (wcnt >= cur_dly);
                wcnt++;
            end else begin
                wcnt = 0;
            end
            main_mem_ac = granted && !cur_op[1];
            lock_ac     = granted && cur_op[1];
        end
    end

    // monitor: every completion pulse is matched against the oldest prediction
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_dat", 32'(rsp_dat), 32'(e.dat));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("last_wait", 32'(last_wait), 32'(e.wt));
                    check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue_op(input logic [1:0] op, input logic [15:0] adr, input logic [15:0] dat,
                            input logic [9:0] ladr, input int dly, input bit track, output int acc);
        exp_t e;
        int   guard;
        bit   err;
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = op;
        req_adr      = adr;
        req_dat      = dat;
        req_lock_adr = ladr;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc;
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        cur_op   = op;
        cur_adr  = adr;
        cur_dat  = dat;
        cur_ladr = ladr;
        cur_dly  = dly;
        if (track) begin
            err   = (op == 2'b10) && (dly >= MAXW);
            e.err = err;
            e.dat = (op == 2'b00) ? ref_mem[adr[7:0]] : 16'h0000;
            e.wt  = err ? 16'(MAXW) : 16'(dly);
            e.lat = err ? (MAXW + 1) : (dly + 2 + ((op == 2'b00) ? 1 : 0));
            e.acc = acc;
            sb_q.push_back(e);
        end
        if (op == 2'b01) ref_mem[adr[7:0]] = dat;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin : stimulus
        int          a0;
        int          a1;
        int          guard;
        logic [1:0]  rop;
        logic [15:0] radr;
        logic [9:0]  rladr;
        int          rdly;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = 2'b00;
        req_adr      = 16'h0;
        req_dat      = 16'h0;
        req_lock_adr = 10'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h1234 + 16'(i);

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_req_lines", 32'({unlock_en, lock_en, main_mem_write, main_mem_read}), 32'd0);
        check("rst_rsp_valid_err", 32'({rsp_valid, rsp_err}), 32'd0);
        check("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        check("rst_last_wait", 32'(last_wait), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        issue_op(2'b01, 16'h0040, 16'hBEEF, 10'd0, 0, 1'b1, a0);
        issue_op(2'b00, 16'h0000, 16'h0000, 10'd0, 0, 1'b1, a0);
        issue_op(2'b01, 16'h0011, 16'h5A5A, 10'd0, 5, 1'b1, a0);
        issue_op(2'b10, 16'h0000, 16'h0000, 10'd3, 1000, 1'b1, a0);
        issue_op(2'b10, 16'h0000, 16'h0000, 10'd7, 1, 1'b1, a0);
        issue_op(2'b11, 16'h0000, 16'h0000, 10'd7, 0, 1'b1, a1);
        check("unlock_accepted_in_done", 32'(a1 - a0), 32'd3);

        // reset while a READ is waiting for its grant
        issue_op(2'b00, 16'h0020, 16'h0000, 10'd0, 1000, 1'b0, a0);
        @(negedge clk);
        check("read_pending_before_rst", 32'(main_mem_read), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midop_rst_req_lines", 32'({unlock_en, lock_en, main_mem_write, main_mem_read}), 32'd0);
        check("midop_rst_ready", 32'(req_ready), 32'd0);
        check("midop_rst_no_rsp", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midop_ready_after_rst", 32'(req_ready), 32'd1);

        for (int n = 0; n < 80; n++) begin
            rop   = 2'($urandom_range(0, 3));
            radr  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(0, 255));
            rladr = 10'($urandom_range(0, 1023));
            rdly  = (rop == 2'b10) ? $urandom_range(0, 10) : $urandom_range(0, 6);
            issue_op(rop, radr, 16'($urandom), rladr, rdly, 1'b1, a0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_mem_port.md
Name: core_mem_port

Overview:
Per-core initiator for the shared main-memory/mutex arbiter. It accepts one memory or lock operation from the core pipeline and drives that core's request lines into the arbiter, holding them until this core's grant bit is seen. It captures read data from the shared synchronous data memory and returns a one-cycle response to the pipeline. One instance sits per core, between the core's MEM stage and the arbiter's per-core port slice.

Parameters:
MAX_WAIT, 0, lock-acquire give-up limit in cycles; 0 = spin forever
WAIT_W, 16, width of the saturating wait counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  core presents an operation
req_ready  out  1  port can accept an operation this cycle
req_op  in  2  op code (mem_pkg op_t)
req_adr  in  16  memory word address (READ/WRITE)
req_dat  in  16  write data
req_lock_adr  in  10  mutex index (LOCK/UNLOCK)
rsp_valid  out  1  one-cycle completion pulse
rsp_dat  out  16  read data (0 for non-READ ops)
rsp_err  out  1  LOCK abandoned on timeout (valid with rsp_valid)
last_wait  out  WAIT_W  grant-wait cycles of the last completed op, saturating
main_mem_read_adr  out  16  request address
main_mem_write_adr  out  16  request address (same value as read_adr)
main_mem_write_dat  out  16  latched write data
main_mem_read  out  1  read request
main_mem_write  out  1  write request
main_mem_ac  in  1  this core's memory grant bit
main_mem_dat  in  16  shared dmem output
lock_adr  out  10  latched mutex index
lock_en  out  1  lock request
unlock_en  out  1  unlock request
lock_ac  in  1  this core's lock grant bit

Behaviour:
- Single clock, clk. reset is synchronous and active-high.
- Reset: state IDLE. All request outputs are 0. rsp_valid, rsp_err and last_wait are 0. rsp_dat is 0. req_ready is forced 0 while reset is high.
- Op codes: READ=00, WRITE=01, LOCK=10, UNLOCK=11.
- States: IDLE, REQ, RDATA, DONE.
- req_ready = 1 in IDLE and DONE.
- Accept: when req_valid && req_ready at a posedge, latch op, addresses and data, clear the wait counter, and go to REQ.
- All arbiter-facing outputs are driven from registers or state only; there is no combinational path from main_mem_ac or lock_ac to any request output.
- REQ state drives exactly one request line, selected by the latched op:
  - READ drives main_mem_read.
  - WRITE drives main_mem_write.
  - LOCK drives lock_en.
  - UNLOCK drives unlock_en.
- In REQ, both main_mem_read_adr and main_mem_write_adr carry the latched address.
- Grant in REQ means the relevant ac bit is 1 at the posedge: main_mem_ac for READ/WRITE, lock_ac for LOCK/UNLOCK.
  - READ, grant at cycle t: go to RDATA (t+1), capture main_mem_dat into rsp_dat at the end of t+1, then DONE (t+2).
  - WRITE, LOCK or UNLOCK, grant at cycle t: go to DONE at t+1 with rsp_dat=0.
- Request lines drop in the cycle after grant. They are never held for two granted cycles, so a lock cannot be re-requested.
- No grant: stay in REQ and increment the wait counter, saturating at all-ones.
- Timeout applies only when MAX_WAIT>0 and the op is LOCK. When the wait counter reaches MAX_WAIT with no grant, go to DONE with rsp_err=1. Other ops never time out.
- DONE lasts one cycle: rsp_valid=1 and last_wait is updated.
  - If a new request is accepted in DONE, go directly to REQ; back-to-back throughput is 1 op per 2 cycles for writes.
  - Otherwise return to IDLE.
- rsp_dat and rsp_err hold their values until the next DONE.
- Reset mid-operation: return to IDLE at the next edge and deassert request lines. An in-flight op is lost. A held mutex is not released; the core is responsible for that.

Decomposition:
- mem_pkg holds:
  - op_t enum: OP_READ, OP_WRITE, OP_LOCK, OP_UNLOCK
  - state_t enum: IDLE, REQ, RDATA, DONE
  - constants ADR_W=16, DAT_W=16, LOCK_W=10
- One sub-module, sat_counter: WAIT_W-bit with clear, enable and saturation. It is used for the wait counter.

Test Plan:
- Write with arbiter granting immediately: WRITE adr=0x0040 dat=0xBEEF, main_mem_ac=1 in the first REQ cycle -> main_mem_write high for 1 cycle with adr 0x0040; rsp_valid the next cycle; last_wait=0.
- Read with model dmem returning 0x1234 one cycle after grant -> rsp_valid 2 cycles after grant, rsp_dat=0x1234; main_mem_read_adr equals main_mem_write_adr.
- Contention: hold main_mem_ac=0 for 5 cycles, then 1 -> request held stable for 6 cycles; last_wait=5.
- Lock timeout: MAX_WAIT=8, LOCK idx=3, lock_ac stuck 0 -> rsp_valid with rsp_err=1 after 8 wait cycles; lock_en then 0.
- Lock then unlock: LOCK idx=7 granted, then UNLOCK idx=7 issued in the DONE cycle -> second op enters REQ directly; unlock_en for 1 cycle; two rsp_valid pulses, both with rsp_err=0.
- Reset during READ in REQ: assert reset -> all request outputs 0 next cycle; req_ready 0 during reset and 1 after; no rsp_valid pulse.
